mole_scheduler: RTL and testbench

Sequences the whack-a-mole round: waits a gap, picks a random switch index, lights that one mole LED for a level-dependent lifetime, and classifies player switch toggles as hit, wrong-switch or timeout miss. Sits between the rng and switch edge detector on the input side, and the LEDR bank and score/game controller on the output side. It replaces the free-running LED toggle logic in the top level.

---
 rtl/mole_scheduler.sv | 145 ++++++++++++++
 tb/tb_mole_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: gap, random pick, timed mole, and hit/miss/wrong
// classification with a level-dependent mole lifetime.
module mole_scheduler #(
    parameter int unsigned WIDTH          = 18,
    parameter int unsigned IDX_W          = 5,
    parameter int unsigned GAP_CYCLES     = 50000000,
    parameter int unsigned LIFE_INIT      = 100000000,
    parameter int unsigned LIFE_STEP      = 10000000,
    parameter int unsigned LIFE_MIN       = 25000000,
    parameter int unsigned HITS_PER_LEVEL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [IDX_W-1:0] rand_idx,
    input  logic [WIDTH-1:0] edge_detect,
    output logic [WIDTH-1:0] mole_leds,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             wrong_pulse,
    output logic [2:0]       level
);

    localparam int unsigned HC_W = $clog2(HITS_PER_LEVEL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PICK = 2'd2,
        UP   = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      gap_cnt;
    logic [31:0]      life_cnt;
    logic [31:0]      life_dec;
    logic [31:0]      life_load;
    logic [2:0]       rej_cnt;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] forced_idx;
    logic [IDX_W-1:0] pick_idx;
    logic [HC_W-1:0]  hit_cnt;
    logic             sample_ok;
    logic             hit;
    logic             wrong;

    // Lifetime shrinks with level but is clamped at the floor instead of wrapping.
    always_comb begin
        life_dec  = 32'(level) * LIFE_STEP;
        life_load = LIFE_MIN;
        if ((LIFE_INIT > life_dec) && ((LIFE_INIT - life_dec) > LIFE_MIN)) begin
            life_load = LIFE_INIT - life_dec;
        end
    end

    assign sample_ok  = (32'(rand_idx) < WIDTH) && (rand_idx != last_idx);
    assign forced_idx = (32'(last_idx) == (WIDTH - 1)) ? '0 : last_idx + IDX_W'(1);
    assign pick_idx   = sample_ok ? rand_idx : forced_idx;

    // mole_leds holds the one-hot active mole while UP, so it doubles as the hit mask.
    assign hit   = |(edge_detect & mole_leds);
    assign wrong = |(edge_detect & ~mole_leds);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            life_cnt    <= '0;
            rej_cnt     <= '0;
            last_idx    <= IDX_W'(WIDTH - 1);
            hit_cnt     <= '0;
            mole_leds   <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
            level       <= '0;
        end else begin
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;

            // Level follows the registered hit pulse, so it moves one cycle after it.
            if (hit_pulse) begin
                if (hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
                    hit_cnt <= '0;
                    if (level != 3'd7) begin
                        level <= level + 3'd1;
                    end
                end else begin
                    hit_cnt <= hit_cnt + HC_W'(1);
                end
            end

            if (!enable) begin
                state     <= IDLE;
                mole_leds <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                    GAP: begin
                        if (gap_cnt == (GAP_CYCLES - 1)) begin
                            state   <= PICK;
                            rej_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 32'd1;
                        end
                    end
                    PICK: begin
                        if (sample_ok || (rej_cnt == 3'd4)) begin
                            last_idx  <= pick_idx;
                            mole_leds <= WIDTH'(1) << pick_idx;
                            life_cnt  <= life_load;
                            state     <= UP;
                        end else begin
                            rej_cnt <= rej_cnt + 3'd1;
                        end
                    end
                    UP: begin
                        if (hit) begin
                            hit_pulse <= 1'b1;
                            mole_leds <= '0;
                            state     <= GAP;
                            gap_cnt   <= '0;
                        end else if (life_cnt == 32'd1) begin
                            miss_pulse <= 1'b1;
                            mole_leds  <= '0;
                            state      <= GAP;
                            gap_cnt    <= '0;
                        end else if (wrong) begin
                            // A wrong toggle freezes the lifetime for that cycle.
                            wrong_pulse <= 1'b1;
                        end else begin
                            life_cnt <= life_cnt - 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed scenarios plus randomized rounds checked
// against a round-level model (pick rule, lifetime formula, level bookkeeping).
module tb_mole_scheduler;

    localparam int WIDTH = 18;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [IDX_W-1:0] rand_idx;
    logic [WIDTH-1:0] edge_detect;
    logic [WIDTH-1:0] mole_leds;
    logic             hit_pulse;
    logic             miss_pulse;
    logic             wrong_pulse;
    logic [2:0]       level;

    mole_scheduler #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .GAP_CYCLES(4), .LIFE_INIT(10),
        .LIFE_STEP(2), .LIFE_MIN(4), .HITS_PER_LEVEL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rand_idx(rand_idx),
        .edge_detect(edge_detect), .mole_leds(mole_leds), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Round-level model state
    int m_last  = WIDTH - 1;
    int m_level = 0;
    int m_hits  = 0;
    int pick_vals[5];

    function automatic int life_of(input int lvl);
        int l;
        l = 10 - 2 * lvl;
        return (l < 4) ? 4 : l;
    endfunction

    function automatic int model_pick(input int last, output int lat);
        for (int k = 0; k < 5; k++) begin
            if (pick_vals[k] < WIDTH && pick_vals[k] != last) begin
                lat = k + 1;
                return pick_vals[k];
            end
        end
        lat = 5;
        return (last + 1) % WIDTH;
    endfunction

    function automatic void model_hit();
        m_hits++;
        if (m_hits == 2) begin
            m_hits = 0;
            if (m_level < 7) m_level++;
        end
    endfunction

    function automatic void model_reset();
        m_last  = WIDTH - 1;
        m_level = 0;
        m_hits  = 0;
    endfunction

    function automatic int onehot_to_int(input logic [WIDTH-1:0] v);
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
        return -2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable; returns just after the edge that enters GAP.
    task automatic do_restart();
        rst_n = 1'b0; enable = 1'b0; edge_detect = '0; rand_idx = '0;
        repeat (3) tick();
        rst_n = 1'b1; enable = 1'b1;
        tick();
        model_reset();
    endtask

    // Called just after the edge that entered GAP; rides out the gap, then feeds pick_vals.
    task automatic gap_and_pick(output int obs_idx, output int obs_lat,
                                output int gap_bad, output int gap_level);
        obs_idx = -1; obs_lat = 0; gap_bad = 0; gap_level = -1;
        for (int g = 0; g < 4; g++) begin
            rand_idx = IDX_W'($urandom_range(0, 31));
            tick();
            if (mole_leds != '0 || hit_pulse || miss_pulse || wrong_pulse) gap_bad = 1;
            if (g == 0) gap_level = int'(level);
        end
        for (int k = 0; k < 5; k++) begin
            rand_idx = IDX_W'(pick_vals[k]);
            tick();
            if (mole_leds != '0) begin
                obs_idx = onehot_to_int(mole_leds);
                obs_lat = k + 1;
                break;
            end
        end
    endtask

    // Called just after the mole appears; drives toggles and records how the mole ends.
    task automatic run_up(input int bit_i, input int hit_j, input int wrong_j, input int wrong_bit,
                          output int lit, output int kind, output int wrongs,
                          output int bad, output int end_level);
        lit = 1; kind = -1; wrongs = 0; bad = 0; end_level = -1;
        for (int j = 0; j < 40; j++) begin
            edge_detect = '0;
            if (j == hit_j) edge_detect[bit_i] = 1'b1;
            if (j == wrong_j) edge_detect[wrong_bit] = 1'b1;
            tick();
            edge_detect = '0;
            if (int'(hit_pulse) + int'(miss_pulse) + int'(wrong_pulse) > 1) bad = 1;
            if (wrong_pulse) wrongs++;
            if (mole_leds == (WIDTH'(1) << bit_i)) begin
                lit++;
                if (hit_pulse || miss_pulse) bad = 1;
            end else begin
                if (mole_leds != '0) bad = 1;
                kind = hit_pulse ? 1 : (miss_pulse ? 2 : 0);
                end_level = int'(level);
                break;
            end
        end
    endtask

    task automatic test_reset();
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level;
        rst_n = 1'b0; enable = 1'b0; edge_detect = '0; rand_idx = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mole_leds, hit_pulse, miss_pulse, wrong_pulse, level} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: leds=%h hit=%b miss=%b wrong=%b level=%0d, required all 0",
                         i, mole_leds, hit_pulse, miss_pulse, wrong_pulse, level);
            end
        end
        model_reset();
        rst_n = 1'b1; enable = 1'b1; rand_idx = 7;
        tick();
        pick_vals = '{7, 7, 7, 7, 7};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (gap_bad !== 0) begin errors++; $display("FAIL start_gap_quiet: got %0d expected 0", gap_bad); end
        checks++;
        if (obs_idx !== exp_idx) begin errors++; $display("FAIL start_idx: got %0d expected %0d", obs_idx, exp_idx); end
        checks++;
        if (obs_lat !== exp_lat) begin errors++; $display("FAIL start_pick_len: got %0d expected %0d", obs_lat, exp_lat); end
        m_last = exp_idx;
    endtask

    task automatic test_timeout();
        int lit, kind, wrongs, bad, end_level;
        run_up(m_last, -1, -1, 0, lit, kind, wrongs, bad, end_level);
        checks++;
        if (lit !== life_of(m_level)) begin errors++; $display("FAIL timeout_life: got %0d expected %0d", lit, life_of(m_level)); end
        checks++;
        if (kind !== 2) begin errors++; $display("FAIL timeout_kind: got %0d expected 2", kind); end
        checks++;
        if (wrongs !== 0 || bad !== 0) begin errors++; $display("FAIL timeout_pulses: wrongs=%0d bad=%0d expected 0 0", wrongs, bad); end
    endtask

    task automatic test_hit_and_wrong();
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level;
        int lit, kind, wrongs, bad, end_level;
        pick_vals = '{20, 3, 3, 3, 3};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx || obs_lat !== exp_lat) begin
            errors++; $display("FAIL hw_pick: got idx %0d len %0d expected idx %0d len %0d", obs_idx, obs_lat, exp_idx, exp_lat);
        end
        checks++;
        if (gap_level !== m_level || gap_bad !== 0) begin
            errors++; $display("FAIL hw_gap: got level %0d bad %0d expected level %0d bad 0", gap_level, gap_bad, m_level);
        end
        m_last = exp_idx;
        run_up(exp_idx, 2, 2, 5, lit, kind, wrongs, bad, end_level);
        checks++;
        if (kind !== 1) begin errors++; $display("FAIL hw_kind: got %0d expected 1", kind); end
        checks++;
        if (wrongs !== 0 || bad !== 0) begin errors++; $display("FAIL hw_only_hit: wrongs=%0d bad=%0d expected 0 0", wrongs, bad); end
        checks++;
        if (lit !== 3) begin errors++; $display("FAIL hw_lit: got %0d expected 3", lit); end
        model_hit();
    endtask

    task automatic test_wrong_then_hit();
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level;
        int lit, kind, wrongs, bad, end_level;
        // An intervening timed-out mole so the next accepted index can be 3 again.
        pick_vals = '{3, 18, 12, 0, 0};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx || obs_lat !== exp_lat) begin
            errors++; $display("FAIL wh_reject_pick: got idx %0d len %0d expected idx %0d len %0d", obs_idx, obs_lat, exp_idx, exp_lat);
        end
        m_last = exp_idx;
        run_up(exp_idx, -1, -1, 0, lit, kind, wrongs, bad, end_level);
        checks++;
        if (lit !== life_of(m_level) || kind !== 2) begin
            errors++; $display("FAIL wh_filler_timeout: got lit %0d kind %0d expected lit %0d kind 2", lit, kind, life_of(m_level));
        end
        pick_vals = '{3, 3, 3, 3, 3};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx || gap_bad !== 0) begin
            errors++; $display("FAIL wh_pick: got idx %0d bad %0d expected idx %0d bad 0", obs_idx, gap_bad, exp_idx);
        end
        m_last = exp_idx;
        run_up(exp_idx, 3, 1, 9, lit, kind, wrongs, bad, end_level);
        checks++;
        if (wrongs !== 1) begin errors++; $display("FAIL wh_wrong_count: got %0d expected 1", wrongs); end
        checks++;
        if (kind !== 1 || lit !== 4 || bad !== 0) begin
            errors++; $display("FAIL wh_hit: got kind %0d lit %0d bad %0d expected kind 1 lit 4 bad 0", kind, lit, bad);
        end
        checks++;
        if (end_level !== m_level) begin errors++; $display("FAIL wh_level_at_hit: got %0d expected %0d", end_level, m_level); end
        model_hit();
    endtask

    // rand_mode=0: rand_idx pinned out of range so every pick is forced, fixed hit/timeout plan.
    task automatic test_rounds(input string name, input int n, input bit rand_mode);
        int plan[11] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level, life;
        int do_hit, hit_j, wrong_j, wrong_bit, exp_wrongs;
        int lit, kind, wrongs, bad, end_level;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < 5; k++) pick_vals[k] = rand_mode ? int'($urandom_range(0, 31)) : 20;
            exp_idx = model_pick(m_last, exp_lat);
            life = life_of(m_level);
            gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
            checks++;
            if (gap_bad !== 0) begin errors++; $display("FAIL %s r%0d gap_quiet: got %0d expected 0", name, r, gap_bad); end
            checks++;
            if (gap_level !== m_level) begin errors++; $display("FAIL %s r%0d level: got %0d expected %0d", name, r, gap_level, m_level); end
            checks++;
            if (obs_idx !== exp_idx) begin errors++; $display("FAIL %s r%0d pick_idx: got %0d expected %0d", name, r, obs_idx, exp_idx); end
            checks++;
            if (obs_lat !== exp_lat) begin errors++; $display("FAIL %s r%0d pick_len: got %0d expected %0d", name, r, obs_lat, exp_lat); end
            m_last = exp_idx;
            do_hit = rand_mode ? int'($urandom_range(0, 3) != 0) : plan[r % 11];
            hit_j = do_hit ? int'($urandom_range(0, life - 1)) : -1;
            wrong_j = -1; wrong_bit = 0;
            if (do_hit != 0 && rand_mode && $urandom_range(0, 1) == 1) begin
                wrong_j = int'($urandom_range(0, hit_j));
                wrong_bit = (exp_idx + int'($urandom_range(1, WIDTH - 1))) % WIDTH;
            end
            exp_wrongs = (wrong_j >= 0 && wrong_j < hit_j) ? 1 : 0;
            run_up(exp_idx, hit_j, wrong_j, wrong_bit, lit, kind, wrongs, bad, end_level);
            checks++;
            if (kind !== (do_hit ? 1 : 2)) begin errors++; $display("FAIL %s r%0d end_kind: got %0d expected %0d", name, r, kind, do_hit ? 1 : 2); end
            checks++;
            if (lit !== (do_hit ? hit_j + 1 : life)) begin
                errors++; $display("FAIL %s r%0d lit_cycles: got %0d expected %0d", name, r, lit, do_hit ? hit_j + 1 : life);
            end
            checks++;
            if (wrongs !== exp_wrongs || bad !== 0) begin
                errors++; $display("FAIL %s r%0d pulses: wrongs %0d bad %0d expected wrongs %0d bad 0", name, r, wrongs, bad, exp_wrongs);
            end
            checks++;
            if (end_level !== m_level) begin errors++; $display("FAIL %s r%0d end_level: got %0d expected %0d", name, r, end_level, m_level); end
            if (do_hit != 0) model_hit();
        end
    endtask

    task automatic test_abort();
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level;
        int lit, kind, wrongs, bad, end_level;
        pick_vals = '{9, 9, 9, 9, 9};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx) begin errors++; $display("FAIL abort_pick: got %0d expected %0d", obs_idx, exp_idx); end
        m_last = exp_idx;
        repeat (2) tick();
        enable = 1'b0;
        edge_detect[exp_idx] = 1'b1;
        tick();
        edge_detect = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mole_leds !== '0 || hit_pulse || miss_pulse || wrong_pulse || level !== 3'(m_level)) begin
                errors++;
                $display("FAIL abort_idle cycle %0d: leds=%h hit=%b miss=%b wrong=%b level=%0d, required leds 0 no pulses level %0d",
                         i, mole_leds, hit_pulse, miss_pulse, wrong_pulse, level, m_level);
            end
            tick();
        end
        enable = 1'b1;
        tick();
        pick_vals = '{2, 2, 2, 2, 2};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (gap_bad !== 0 || obs_idx !== exp_idx || obs_lat !== exp_lat) begin
            errors++; $display("FAIL abort_restart: got bad %0d idx %0d len %0d expected bad 0 idx %0d len %0d",
                               gap_bad, obs_idx, obs_lat, exp_idx, exp_lat);
        end
        m_last = exp_idx;
        run_up(exp_idx, 0, -1, 0, lit, kind, wrongs, bad, end_level);
        checks++;
        if (kind !== 1 || lit !== 1) begin errors++; $display("FAIL abort_rehit: got kind %0d lit %0d expected kind 1 lit 1", kind, lit); end
        model_hit();
    endtask

    task automatic test_reset_mid();
        int exp_idx, exp_lat, obs_idx, obs_lat, gap_bad, gap_level;
        pick_vals = '{5, 6, 7, 8, 9};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx) begin errors++; $display("FAIL rmid_pick: got %0d expected %0d", obs_idx, exp_idx); end
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({mole_leds, hit_pulse, miss_pulse, wrong_pulse, level} !== '0) begin
            errors++; $display("FAIL rmid_outputs: leds=%h hit=%b miss=%b wrong=%b level=%0d, required all 0",
                               mole_leds, hit_pulse, miss_pulse, wrong_pulse, level);
        end
        model_reset();
        rst_n = 1'b1;
        tick();
        pick_vals = '{20, 20, 20, 20, 20};
        exp_idx = model_pick(m_last, exp_lat);
        gap_and_pick(obs_idx, obs_lat, gap_bad, gap_level);
        checks++;
        if (obs_idx !== exp_idx || obs_lat !== exp_lat || gap_bad !== 0) begin
            errors++; $display("FAIL rmid_first_forced: got idx %0d len %0d bad %0d expected idx %0d len %0d bad 0",
                               obs_idx, obs_lat, gap_bad, exp_idx, exp_lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; edge_detect = '0; rand_idx = '0;
        test_reset();
        test_timeout();
        test_hit_and_wrong();
        test_wrong_then_hit();
        do_restart();
        test_rounds("level_floor", 11, 1'b0);
        test_rounds("random", 40, 1'b1);
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
